// File: rtl/sort_frame_if.sv
// sort_frame_if: valid/ready input and output element streams of the sort frame controller
interface sort_frame_if #(parameter int DATA_WIDTH = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_frame_controller.sv
// sort_frame_controller: loads a frame into the serial sorter, drains it sorted, then clears the sorter
module sort_frame_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  sort_frame_if.slave           bus,
  output logic                  truncated,
  output logic                  sort_enable,
  output logic                  sort_write,
  output logic [DATA_WIDTH-1:0] sort_unsorted,
  output logic                  sort_clear_n,
  input  logic [DATA_WIDTH-1:0] sort_sorted
);
  localparam int CW = $clog2(SIZE + 1);
  typedef enum logic [1:0] {LOAD, DRAIN, CLEAR} state_t;
  state_t          state, next;
  logic [CW-1:0]   count, next_count;
  logic            accept, pop;
  always_comb begin
    accept        = state == LOAD && bus.in_valid && bus.in_ready;
    pop           = state == DRAIN && bus.out_valid && bus.out_ready;
    sort_enable   = accept || pop;
    sort_write    = !pop;
    sort_unsorted = bus.in_data;
    bus.out_data  = sort_sorted;
    next_count    = accept ? count + CW'(1) : pop ? count - CW'(1) : count;
    next          = state == CLEAR ? LOAD :
                    accept && (bus.in_last || count == CW'(SIZE - 1)) ? DRAIN :
                    pop && count == CW'(1) ? CLEAR : state;
  end
  // Registered outputs are computed from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= LOAD;
      count         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      truncated     <= 1'b0;
      sort_clear_n  <= 1'b0;
    end else begin
      state         <= next;
      count         <= next_count;
      bus.in_ready  <= next == LOAD;
      bus.out_valid <= next == DRAIN && next_count != '0;
      bus.out_last  <= next == DRAIN && next_count == CW'(1);
      truncated     <= (accept && next == DRAIN && !bus.in_last) ||
                       (truncated && !(accept && count == '0));
      sort_clear_n  <= next != CLEAR;
    end
  end
endmodule
